cfg_loader: RTL and testbench
=============================

Name: cfg_loader

Overview:
- Serial configuration loader that sits directly upstream of the `sram` config/LUT memory.
- Accepts a bit-serial configuration stream and assembles DATA_WIDTH-bit words.
- Drives the sram write port (`waddr`, `wdata`, `we`) with sequential addresses 0..2**ADDR_WIDTH-1.
- Flags completion so fabric logic may start reading the loaded contents.

Parameters:
- ADDR_WIDTH, 4, sram address width; number of words loaded = 2**ADDR_WIDTH.
- DATA_WIDTH, 1, sram word width; bits assembled per write.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse; (re)starts a load from address 0.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial configuration bit, MSB of each word first.
- waddr  output  ADDR_WIDTH  sram write address.
- wdata  output  DATA_WIDTH  sram write data.
- we  output  1  sram write enable, one-cycle pulse per word.
- cfg_busy  output  1  high while in LOAD (or PARITY).
- cfg_done  output  1  high once all words are written; held until the next start or reset.
- cfg_err  output  1  parity error flag (see Optional Feature).

Behaviour:
- **Reset:** asynchronous, active-high. States and outputs are cleared as follows:
  - state = IDLE.
  - `waddr` = 0, `wdata` = 0, `we` = 0.
  - `cfg_busy` = 0, `cfg_done` = 0, `cfg_err` = 0.
  - bit counter, word counter and shift register = 0.
- **States:** IDLE, LOAD, PARITY (macro only), DONE.
- **IDLE:**
  - `cfg_start` → LOAD; clear counters, shift register, `cfg_done` and `cfg_err`.
  - `cfg_valid` is ignored.
- **LOAD, bit capture:**
  - Each cycle with `cfg_valid` = 1: shift register <= {shift[DATA_WIDTH-2:0], cfg_bit}, and the bit counter increments.
  - When DATA_WIDTH = 1, the shift register is simply cfg_bit.
  - `cfg_valid` = 0 stalls with no state change; gaps of any length are allowed.
- **LOAD, word write:**
  - On the edge capturing bit DATA_WIDTH-1 of a word:
    - `we` <= 1.
    - `wdata` <= the completed word.
    - `waddr` <= word counter.
    - bit counter <= 0; word counter increments.
  - `we` is high for exactly one cycle; write latency is 1 cycle after the last bit of the word.
  - Back-to-back writes every cycle are legal (DATA_WIDTH = 1, continuous valid).
- **Last word:**
  - Final bit of word 2**ADDR_WIDTH-1 captured at edge N → `we` is high in cycle N.
  - State goes to DONE at edge N (or PARITY with the macro), so `cfg_done` is high from edge N+1.
  - The word counter must not wrap into a 17th write; it is ADDR_WIDTH+1 bits wide, or the terminal count is detected explicitly.
- **DONE:**
  - `cfg_done` = 1, `cfg_busy` = 0, `we` = 0.
  - Extra `cfg_valid` bits are ignored.
  - `cfg_start` → LOAD (full reload from address 0), clearing `cfg_done`.
- **cfg_start during LOAD/PARITY:**
  - Aborts the current load and restarts at address 0.
  - The partial word is discarded and not written.
  - Already-written sram words stay as they are until overwritten.
- **Simultaneous cfg_start and cfg_valid:** `cfg_start` wins; the bit is dropped.
- **Reset mid-load:**
  - `we` drops immediately (asynchronously); no partial write occurs.
  - sram contents are not cleared by this block.
- **Output registering:** all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CFG_PARITY_EN.
- **Defined:**
  - After the last data bit, the FSM enters PARITY and waits for one further valid bit.
  - Even parity: the XOR of all loaded data bits plus the parity bit must equal 0.
  - On that bit's capture edge: state → DONE, `cfg_done` <= 1, `cfg_err` <= 1 if the parity is odd, else 0.
  - A running parity register is cleared on start and reset.
  - `cfg_busy` stays high in PARITY.
  - Writes are not suppressed on error; `cfg_err` is advisory to the controller.
- **Undefined:**
  - No PARITY state and no parity register.
  - `cfg_err` is tied to 0; the port remains for a stable interface.

Decomposition:
- Shared package `cfg_pkg` holds:
  - state encoding localparams: IDLE = 2'd0, LOAD = 2'd1, PARITY = 2'd2, DONE = 2'd3.
  - default ADDR_WIDTH and DATA_WIDTH constants, shared with `sram`.
- One natural sub-module: `cfg_shift_reg` (DATA_WIDTH shift register plus bit counter, with a "word_ready" strobe).
- FSM, address counter and parity logic stay in the top module.

Test Plan:
- **Full load, default params:** reset, `cfg_start`, 16 consecutive valid bits 1,0,1,1,... → 16 `we` pulses on consecutive cycles, `waddr` 0..15, `wdata` equal to each bit; `cfg_done` = 1 the cycle after the waddr = 15 pulse; read-back through `sram` matches.
- **DATA_WIDTH = 4, ADDR_WIDTH = 2, with gaps:** stream 0xA, 0x5, 0xF, 0x3 MSB-first, `cfg_valid` low every other cycle → 4 writes (0→A, 1→5, 2→F, 3→3), each `we` exactly 1 cycle after the 4th bit; no writes during gaps.
- **Abort/restart:** `cfg_start` after 6 bits of a 4-bit-word load → 1 write (addr 0), the 2-bit partial is discarded, the next write goes to addr 0 again; `cfg_done` only after a complete reload.
- **Reset mid-load:** assert `rst` while `we` = 1 → `we`, `waddr`, `wdata`, `cfg_busy` and `cfg_done` are 0 immediately and stay 0 until the next `cfg_start`; bits after reset and before start produce no writes.
- **Post-done robustness:** 20 extra valid bits in DONE → no `we`, `cfg_done` stays 1; a following `cfg_start` clears `cfg_done` and reloads.
- **CFG_PARITY_EN:**
  - 16 bits with four 1s, then parity bit 0 → `cfg_done` = 1, `cfg_err` = 0.
  - Repeat with parity bit 1 → `cfg_err` = 1.
  - `cfg_done` must not assert before the parity bit arrives.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration loader and the sram it feeds.
// Optional feature macro: CFG_PARITY_EN (adds the PARITY state and the
// advisory cfg_err parity check).
package cfg_pkg;

  // Default geometry, shared with the sram config/LUT memory.
  localparam int CFG_ADDR_WIDTH = 4;
  localparam int CFG_DATA_WIDTH = 1;

  // Loader FSM state encoding.
  typedef logic [1:0] cfg_state_t;
  localparam cfg_state_t IDLE   = 2'd0;
  localparam cfg_state_t LOAD   = 2'd1;
  localparam cfg_state_t PARITY = 2'd2;
  localparam cfg_state_t DONE   = 2'd3;

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-to-parallel word assembler: collects DATA_WIDTH bits MSB-first and
// raises word_ready on the cycle whose shift completes a word. next_word is
// the word as it will look after the current shift, so the caller can
// register it on the same edge.
module cfg_shift_reg #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] next_word,
  output logic                  word_ready
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CW-1:0] bit_cnt;

  assign word_ready = shift_en && (bit_cnt == CW'(DATA_WIDTH - 1));

  // Only the low DATA_WIDTH-1 bits need storage: the oldest bit of a full
  // word is consumed on the very edge that completes it.
  generate
    if (DATA_WIDTH == 1) begin : g_bit
      assign next_word = bit_in;
    end else begin : g_vec
      logic [DATA_WIDTH-2:0] low_q;

      assign next_word = {low_q, bit_in};

      // Shift storage: cleared on reset/restart, shifts on each accepted bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          low_q <= '0;
        end else if (clr) begin
          low_q <= '0;
        end else if (shift_en) begin
          low_q <= next_word[DATA_WIDTH-2:0];
        end
      end
    end
  endgenerate

  // Bit counter: wraps to zero on the bit that completes a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= word_ready ? '0 : CW'(bit_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader feeding the sram write port.
// Optional feature macro: CFG_PARITY_EN. When defined, one extra even-parity
// bit follows the data and sets cfg_err if the overall parity is odd; when
// undefined cfg_err is tied low.
//
// Stream handshake: cfg_valid qualifies cfg_bit for one cycle; there is no
// ready, the loader consumes every valid bit while in LOAD (or PARITY) and
// silently drops bits in IDLE/DONE or on a cycle where cfg_start is high.
// All outputs are registered; dbg_state exposes the FSM state.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int DATA_WIDTH = CFG_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  // One extra bit so the counter can reach NUM_WORDS without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

  cfg_state_t            state_q, state_d;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic                  shift_en;
  logic                  word_ready;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  we_d;
  logic                  busy_d;
  logic                  done_d;

  assign shift_en  = (state_q == LOAD) && cfg_valid && !cfg_start;
  assign last_word = word_ready && (word_cnt == LAST_WORD);
  assign dbg_state = state_q;

  cfg_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr        (cfg_start),
    .shift_en   (shift_en),
    .bit_in     (cfg_bit),
    .next_word  (next_word),
    .word_ready (word_ready)
  );

`ifdef CFG_PARITY_EN
  logic par_q;
  logic par_cap;
  logic err_d;

  assign par_cap = (state_q == PARITY) && cfg_valid && !cfg_start;

  // Running XOR of every accepted data bit since the last start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (cfg_start) begin
      par_q <= 1'b0;
    end else if (shift_en) begin
      par_q <= par_q ^ cfg_bit;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cfg_start restarts the load from any state.
  always_comb begin
    state_d = state_q;
    if (cfg_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (last_word) begin
`ifdef CFG_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef CFG_PARITY_EN
        PARITY: begin
          if (par_cap) state_d = DONE;
        end
`endif
        DONE:    state_d = DONE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    we_d   = shift_en && word_ready;
    busy_d = (state_d == LOAD) || (state_d == PARITY);
    done_d = cfg_done;
    if (cfg_start) begin
      done_d = 1'b0;
    end else if (state_q == DONE) begin
      done_d = 1'b1;
`ifdef CFG_PARITY_EN
    end else if (par_cap) begin
      done_d = 1'b1;
`endif
    end
`ifdef CFG_PARITY_EN
    err_d = cfg_err;
    if (cfg_start) begin
      err_d = 1'b0;
    end else if (par_cap) begin
      err_d = par_q ^ cfg_bit;
    end
`endif
  end

  // Word counter: address of the next word to be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (cfg_start) begin
      word_cnt <= '0;
    end else if (shift_en && word_ready) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Registered outputs; waddr/wdata hold their last written values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      we       <= we_d;
      cfg_busy <= busy_d;
      cfg_done <= done_d;
      if (we_d) begin
        waddr <= word_cnt[ADDR_WIDTH-1:0];
        wdata <= next_word;
      end
    end
  end

`ifdef CFG_PARITY_EN
  // Advisory parity error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= err_d;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: one default-geometry instance (16 x 1-bit) and one
// 4 x 4-bit instance, driven by directed steps with random bits and gaps,
// checked every cycle against a stream-level model and an sram image.
module tb_cfg_loader;

`ifdef CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s0 = 0, v0 = 0, b0 = 0, s1 = 0, v1 = 0, b1 = 0;
  logic [3:0] waddr0;
  logic [0:0] wdata0;
  logic       we0, busy0, done0, err0;
  logic [1:0] st0;
  logic [1:0] waddr1;
  logic [3:0] wdata1;
  logic       we1, busy1, done1, err1;
  logic [1:0] st1;

  cfg_loader u0 (
    .clk(clk), .rst(rst), .cfg_start(s0), .cfg_valid(v0), .cfg_bit(b0),
    .waddr(waddr0), .wdata(wdata0), .we(we0), .cfg_busy(busy0),
    .cfg_done(done0), .cfg_err(err0), .dbg_state(st0)
  );

  cfg_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .cfg_start(s1), .cfg_valid(v1), .cfg_bit(b1),
    .waddr(waddr1), .wdata(wdata1), .we(we1), .cfg_busy(busy1),
    .cfg_done(done1), .cfg_err(err1), .dbg_state(st1)
  );

  int checks = 0;
  int errors = 0;

  // Stream-level model: mode 0 idle, 1 loading, 2 awaiting parity, 3 done.
  int dw[2] = '{1, 4};
  int nw[2] = '{16, 4};
  int m_mode[2], m_nbits[2], m_cur[2], m_wcnt[2], m_par[2];
  int m_we[2], m_waddr[2], m_wdata[2], m_done[2], m_busy[2], m_err[2];
  int mem_exp[2][16];
  int mem_obs[2][16];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_nbits[k] = 0; m_cur[k] = 0; m_wcnt[k] = 0; m_par[k] = 0;
      m_we[k] = 0; m_waddr[k] = 0; m_wdata[k] = 0; m_done[k] = 0;
      m_busy[k] = 0; m_err[k] = 0;
    end
  endtask

  // One clock cycle on the selected instance, then compare all its outputs.
  task automatic step(int sel, bit s, bit v, bit b);
    int prev;
    logic o_we, o_done, o_busy, o_err;
    logic [31:0] o_addr, o_data;
    if (sel == 0) begin
      s0 = s; v0 = v; b0 = b; s1 = 0; v1 = 0; b1 = 0;
    end else begin
      s1 = s; v1 = v; b1 = b; s0 = 0; v0 = 0; b0 = 0;
    end
    @(posedge clk);
    #1;
    prev = m_mode[sel];
    m_we[sel] = 0;
    if (s) begin
      m_mode[sel] = 1; m_nbits[sel] = 0; m_cur[sel] = 0; m_wcnt[sel] = 0;
      m_par[sel] = 0; m_done[sel] = 0; m_err[sel] = 0;
    end else if (prev == 1 && v) begin
      m_cur[sel] = ((m_cur[sel] << 1) | int'(b)) & ((1 << dw[sel]) - 1);
      m_par[sel] = m_par[sel] ^ int'(b);
      m_nbits[sel]++;
      if (m_nbits[sel] == dw[sel]) begin
        m_nbits[sel] = 0;
        m_we[sel] = 1;
        m_waddr[sel] = m_wcnt[sel];
        m_wdata[sel] = m_cur[sel];
        mem_exp[sel][m_wcnt[sel]] = m_cur[sel];
        m_wcnt[sel]++;
        if (m_wcnt[sel] == nw[sel]) m_mode[sel] = PAR ? 2 : 3;
      end
    end else if (prev == 2 && v) begin
      m_mode[sel] = 3;
      m_done[sel] = 1;
      m_err[sel] = m_par[sel] ^ int'(b);
    end
    if (!s && prev == 3) m_done[sel] = 1;
    m_busy[sel] = (m_mode[sel] == 1 || m_mode[sel] == 2) ? 1 : 0;

    if (sel == 0) begin
      o_we = we0; o_addr = 32'(waddr0); o_data = 32'(wdata0);
      o_done = done0; o_busy = busy0; o_err = err0;
    end else begin
      o_we = we1; o_addr = 32'(waddr1); o_data = 32'(wdata1);
      o_done = done1; o_busy = busy1; o_err = err1;
    end
    if (o_we === 1'b1) mem_obs[sel][o_addr[3:0]] = int'(o_data);
    chk($sformatf("d%0d_we", sel), 32'(o_we), 32'(m_we[sel]));
    chk($sformatf("d%0d_waddr", sel), o_addr, 32'(m_waddr[sel]));
    chk($sformatf("d%0d_wdata", sel), o_data, 32'(m_wdata[sel]));
    chk($sformatf("d%0d_done", sel), 32'(o_done), 32'(m_done[sel]));
    chk($sformatf("d%0d_busy", sel), 32'(o_busy), 32'(m_busy[sel]));
    chk($sformatf("d%0d_err", sel), 32'(o_err), 32'(m_err[sel]));
  endtask

  task automatic send_word(int sel, logic [31:0] w, bit gap);
    for (int i = dw[sel] - 1; i >= 0; i--) begin
      step(sel, 1'b0, 1'b1, w[i]);
      if (gap) step(sel, 1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic parity_bit(int sel, bit b);
    if (PAR) step(sel, 1'b0, 1'b1, b);
  endtask

  task automatic idle(int sel, int n);
    for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic mem_chk(int sel);
    for (int i = 0; i < nw[sel]; i++)
      chk($sformatf("d%0d_mem%0d", sel, i), 32'(mem_obs[sel][i]), 32'(mem_exp[sel][i]));
  endtask

  initial begin
    logic [15:0] pat;
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        mem_exp[k][i] = 0;
        mem_obs[k][i] = 0;
      end

    // Reset state.
    @(negedge clk);
    chk("rst_we0", 32'(we0), 0);
    chk("rst_waddr0", 32'(waddr0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_err0", 32'(err0), 0);
    chk("rst_we1", 32'(we1), 0);
    chk("rst_wdata1", 32'(wdata1), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full load, default geometry, continuous valid: one write per cycle.
    pat = 16'b1011_0010_1110_0101;
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) step(0, 1'b0, 1'b1, pat[i]);
    parity_bit(0, ^pat);
    idle(0, 2);
    mem_chk(0);

    // Extra bits in DONE are ignored; then a random reload with random gaps.
    for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b1, 1'($urandom));
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b0, 1'b1, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3));
    end
    parity_bit(0, 1'($urandom));
    idle(0, 2);
    mem_chk(0);

    // Reset mid-load while a write strobe is high.
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b1);
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_we0", 32'(we0), 0);
    chk("arst_waddr0", 32'(waddr0), 0);
    chk("arst_wdata0", 32'(wdata0), 0);
    chk("arst_busy0", 32'(busy0), 0);
    chk("arst_done0", 32'(done0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 1'($urandom));

    // 4-bit words with a gap after every bit.
    step(1, 1'b1, 1'b0, 1'b0);
    send_word(1, 32'hA, 1'b1);
    send_word(1, 32'h5, 1'b1);
    send_word(1, 32'hF, 1'b1);
    send_word(1, 32'h3, 1'b1);
    parity_bit(1, 1'b0);
    idle(1, 2);
    mem_chk(1);

    // Abort after six bits (start coincides with a valid bit), then reload.
    step(1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1, 1'b0, 1'b1, 1'($urandom));
    step(1, 1'b1, 1'b1, 1'b1);
    for (int w = 0; w < 4; w++) send_word(1, 32'($urandom_range(0, 15)), 1'($urandom));
    parity_bit(1, 1'($urandom));
    idle(1, 2);
    mem_chk(1);

`ifdef CFG_PARITY_EN
    // Four ones in the data: parity bit 0 is clean, parity bit 1 is an error.
    pat = 16'h8421;
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) step(0, 1'b0, 1'b1, pat[i]);
    idle(0, 2);
    step(0, 1'b0, 1'b1, 1'b0);
    chk("par_ok_err", 32'(err0), 0);
    chk("par_ok_done", 32'(done0), 1);
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) step(0, 1'b0, 1'b1, pat[i]);
    step(0, 1'b0, 1'b1, 1'b1);
    chk("par_bad_err", 32'(err0), 1);
    chk("par_bad_done", 32'(done0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit reached");
  end

endmodule
